// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
//   Shared RV32I decode definitions: opcode constants, immediate formats and
//   the decoded-bundle struct handed from decode to execute.
// ---------------------------------------------------------------------------
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   typedef struct packed {
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            alu_src;
      logic            illegal;
   } decoded_t;

   localparam int DECODED_W = $bits(decoded_t);

endpackage

// File: rtl/instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
//   Purely combinational RV32I field, immediate and control decode.
//   Ports:
//     instr  in   raw 32-bit instruction
//     dec    out  decoded bundle (fields, sign-extended immediate, controls)
// ---------------------------------------------------------------------------
module instr_decoder
   import rv32_pkg::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   imm_fmt_e fmt;

   // NOTE: every output of a combinational block gets a default before any
   //       branching, so no path leaves a value held and no latch is inferred.
   always_comb begin
      dec        = '0;
      fmt        = IMM_NONE;
      dec.instr  = instr;
      dec.rd     = instr[11:7];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.funct3 = instr[14:12];
      dec.funct7 = instr[31:25];

      if (instr[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end else begin
         case (instr[6:0])
            OPC_OP: begin
               dec.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
               dec.reg_write = 1'b1;
               dec.alu_src   = 1'b1;
               fmt           = IMM_I;
            end
            OPC_LOAD: begin
               dec.reg_write = 1'b1;
               dec.mem_read  = 1'b1;
               dec.alu_src   = 1'b1;
               fmt           = IMM_I;
            end
            OPC_STORE: begin
               dec.mem_write = 1'b1;
               dec.alu_src   = 1'b1;
               fmt           = IMM_S;
            end
            OPC_BRANCH: begin
               dec.branch = 1'b1;
               fmt        = IMM_B;
            end
            OPC_JAL: begin
               dec.jump      = 1'b1;
               dec.reg_write = 1'b1;
               fmt           = IMM_J;
            end
            OPC_JALR: begin
               dec.jump      = 1'b1;
               dec.reg_write = 1'b1;
               dec.alu_src   = 1'b1;
               fmt           = IMM_I;
            end
            OPC_LUI, OPC_AUIPC: begin
               dec.reg_write = 1'b1;
               dec.alu_src   = 1'b1;
               fmt           = IMM_U;
            end
            default: begin
               dec.illegal = 1'b1;
            end
         endcase
      end

      case (fmt)
         IMM_I:   dec.imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   dec.imm = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
         IMM_U:   dec.imm = {instr[31:12], 12'b0};
         IMM_J:   dec.imm = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
         default: dec.imm = '0;
      endcase

      // x0 is hardwired to zero, so a write to it is never architectural.
      if (dec.rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
   end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Decode stage: decodes fetched instructions and holds them in a 2-entry
//   buffer (output register + skid register) in front of execute.
//   Ports:
//     clk, reset_n           clock, synchronous active-low reset
//     if_valid/if_ready      fetch handshake; if_instr, if_pc payload
//     flush                  drop all held and incoming instructions
//     ex_valid/ex_ready      execute handshake
//     ex_pc, ex_instr        PC and raw instruction of the held bundle
//     ex_rd .. ex_funct7     register indices and function fields
//     ex_imm                 sign-extended immediate
//     ex_reg_write .. ex_illegal  decoded control bits
// ---------------------------------------------------------------------------
module id_stage
   import rv32_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [31:0]     ex_instr,
   output logic [4:0]      ex_rd,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [2:0]      ex_funct3,
   output logic [6:0]      ex_funct7,
   output logic [31:0]     ex_imm,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_branch,
   output logic            ex_jump,
   output logic            ex_alu_src,
   output logic            ex_illegal
);

   localparam int ENTRY_W = XLEN + DECODED_W;

   decoded_t            if_dec;
   decoded_t            nop_bundle;
   decoded_t            out_q;
   logic [XLEN-1:0]     out_pc_q;
   logic                out_valid_q;
   logic [ENTRY_W-1:0]  skid_q;
   logic                skid_valid_q;
   logic                accept;
   logic                out_free;

   instr_decoder u_decoder (
      .instr (if_instr),
      .dec   (if_dec)
   );

   always_comb begin
      nop_bundle       = '0;
      nop_bundle.instr = NOP_INSTR;
   end

   // Ready depends only on registered skid state, never on ex_ready.
   assign if_ready = reset_n & ~skid_valid_q;
   assign accept   = if_valid & if_ready;
   assign out_free = ~out_valid_q | ex_ready;

   // NOTE: state registers use non-blocking assignments so every register
   //       samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= nop_bundle;
         out_pc_q     <= '0;
      end else if (flush) begin
         // A hand-off this cycle is still consumed; everything else is lost.
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q.instr  <= NOP_INSTR;
      end else if (out_free) begin
         if (skid_valid_q) begin
            {out_pc_q, out_q} <= skid_q;
            out_valid_q       <= 1'b1;
            skid_valid_q      <= accept;
         end else if (accept) begin
            out_q       <= if_dec;
            out_pc_q    <= if_pc;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_valid_q <= 1'b1;
      end
   end

   // NOTE: the skid payload is qualified by skid_valid_q, so it needs no
   //       reset; only the control bits and the visible outputs are reset.
   always_ff @(posedge clk) begin
      if (accept && (skid_valid_q || !out_free)) begin
         skid_q <= {if_pc, if_dec};
      end
   end

   // if_ready is low whenever skid is full, so a fill into a full skid
   // while it is also draining must never happen.
   a_no_skid_overrun : assert property (
      @(posedge clk) disable iff (!reset_n) !(skid_valid_q && accept));

   assign ex_valid     = out_valid_q;
   assign ex_pc        = out_pc_q;
   assign ex_instr     = out_q.instr;
   assign ex_rd        = out_q.rd;
   assign ex_rs1       = out_q.rs1;
   assign ex_rs2       = out_q.rs2;
   assign ex_funct3    = out_q.funct3;
   assign ex_funct7    = out_q.funct7;
   assign ex_imm       = out_q.imm;
   assign ex_reg_write = out_q.reg_write;
   assign ex_mem_read  = out_q.mem_read;
   assign ex_mem_write = out_q.mem_write;
   assign ex_branch    = out_q.branch;
   assign ex_jump      = out_q.jump;
   assign ex_alu_src   = out_q.alu_src;
   assign ex_illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//   Directed self-checking bench for id_stage.
// ---------------------------------------------------------------------------
module tb_id_stage;

   logic        clk;
   logic        reset_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_instr;
   logic [4:0]  ex_rd;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;
   logic [31:0] ex_imm;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_branch;
   logic        ex_jump;
   logic        ex_alu_src;
   logic        ex_illegal;

   int checks = 0;
   int errors = 0;

   id_stage dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .if_valid     (if_valid),
      .if_ready     (if_ready),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .flush        (flush),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_pc        (ex_pc),
      .ex_instr     (ex_instr),
      .ex_rd        (ex_rd),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_funct3    (ex_funct3),
      .ex_funct7    (ex_funct7),
      .ex_imm       (ex_imm),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_branch    (ex_branch),
      .ex_jump      (ex_jump),
      .ex_alu_src   (ex_alu_src),
      .ex_illegal   (ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr,
                        input logic [31:0] pc);
      if_valid = v;
      if_instr = instr;
      if_pc    = pc;
   endtask

   function automatic logic [31:0] addi_enc(input int rd, input int imm);
      return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
   endfunction

   int  sent;
   int  rcvd;
   bit  saw_backpressure;
   bit  acc;

   initial begin
      reset_n  = 1'b0;
      flush    = 1'b0;
      ex_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      step();
      step();

      // ---------------- reset state ----------------
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_ex_instr", ex_instr, 32'h00000013);
      check("rst_ex_imm", ex_imm, 32'd0);
      check("rst_ex_pc", ex_pc, 32'd0);
      check("rst_reg_write", 32'(ex_reg_write), 32'd0);

      reset_n = 1'b1;
      #1;
      check("post_rst_if_ready", 32'(if_ready), 32'd1);

      // ---------------- addi x1,x1,1 ----------------
      drive(1'b1, 32'h00108093, 32'h100);
      step();
      check("addi_valid", 32'(ex_valid), 32'd1);
      check("addi_rd", 32'(ex_rd), 32'd1);
      check("addi_rs1", 32'(ex_rs1), 32'd1);
      check("addi_imm", ex_imm, 32'd1);
      check("addi_reg_write", 32'(ex_reg_write), 32'd1);
      check("addi_alu_src", 32'(ex_alu_src), 32'd1);
      check("addi_pc", ex_pc, 32'h100);

      // ---------------- sw x2,8(x1) ----------------
      drive(1'b1, 32'h0020A423, 32'h104);
      step();
      check("sw_imm", ex_imm, 32'd8);
      check("sw_rs1", 32'(ex_rs1), 32'd1);
      check("sw_rs2", 32'(ex_rs2), 32'd2);
      check("sw_mem_write", 32'(ex_mem_write), 32'd1);
      check("sw_reg_write", 32'(ex_reg_write), 32'd0);
      check("sw_funct3", 32'(ex_funct3), 32'd2);

      // ---------------- beq x0,x0,-4 ----------------
      drive(1'b1, 32'hFE000EE3, 32'h108);
      step();
      check("beq_imm", ex_imm, 32'hFFFFFFFC);
      check("beq_branch", 32'(ex_branch), 32'd1);
      check("beq_reg_write", 32'(ex_reg_write), 32'd0);

      // ---------------- jal x1,8 ----------------
      drive(1'b1, 32'h008000EF, 32'h10C);
      step();
      check("jal_imm", ex_imm, 32'd8);
      check("jal_jump", 32'(ex_jump), 32'd1);
      check("jal_reg_write", 32'(ex_reg_write), 32'd1);

      // ---------------- lui x1,0x12345 ----------------
      drive(1'b1, 32'h123450B7, 32'h110);
      step();
      check("lui_imm", ex_imm, 32'h12345000);
      check("lui_alu_src", 32'(ex_alu_src), 32'd1);

      // ---------------- illegal 0xFFFFFFFF ----------------
      drive(1'b1, 32'hFFFFFFFF, 32'h114);
      step();
      check("ill_valid", 32'(ex_valid), 32'd1);
      check("ill_illegal", 32'(ex_illegal), 32'd1);
      check("ill_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write,
                         ex_branch, ex_jump}, 32'd0);

      // ---------------- nop: rd=0 forces reg_write=0 ----------------
      drive(1'b1, 32'h00000013, 32'h118);
      step();
      check("nop_reg_write", 32'(ex_reg_write), 32'd0);
      check("nop_illegal", 32'(ex_illegal), 32'd0);
      check("nop_alu_src", 32'(ex_alu_src), 32'd1);

      drive(1'b0, 32'h0, 32'h0);
      step();
      check("idle_valid", 32'(ex_valid), 32'd0);
      check("idle_hold_pc", ex_pc, 32'h118);

      // ---------------- stream of 5 with a 3-cycle stall ----------------
      sent             = 0;
      rcvd             = 0;
      saw_backpressure = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         ex_ready = !(cyc >= 3 && cyc < 6);
         if (sent < 5) drive(1'b1, addi_enc(sent + 1, sent), 32'(sent * 4));
         else          drive(1'b0, 32'h0, 32'h0);
         #1;
         if (ex_valid && ex_ready) begin
            check("stream_pc", ex_pc, 32'(rcvd * 4));
            check("stream_instr", ex_instr, addi_enc(rcvd + 1, rcvd));
            rcvd++;
         end
         if (!if_ready) saw_backpressure = 1'b1;
         acc = if_valid && if_ready;
         step();
         if (acc) sent++;
         if (sent == 5 && rcvd == 5) break;
      end
      check("stream_count", 32'(rcvd), 32'd5);
      check("stream_backpressure", 32'(saw_backpressure), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      ex_ready = 1'b1;
      step();
      check("stream_no_dup", 32'(ex_valid), 32'd0);

      // ---------------- flush with both entries full ----------------
      ex_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h200);
      step();
      drive(1'b1, 32'h00200113, 32'h204);
      step();
      check("full_if_ready", 32'(if_ready), 32'd0);
      check("full_ex_pc", ex_pc, 32'h200);
      flush = 1'b1;
      drive(1'b1, 32'h00300193, 32'h208);
      step();
      flush = 1'b0;
      check("flush_valid", 32'(ex_valid), 32'd0);
      check("flush_if_ready", 32'(if_ready), 32'd1);
      check("flush_instr", ex_instr, 32'h00000013);

      // beat accepted during flush is dropped
      flush = 1'b1;
      drive(1'b1, 32'h00400213, 32'h20C);
      step();
      flush = 1'b0;
      check("flush_drop_valid", 32'(ex_valid), 32'd0);

      ex_ready = 1'b1;
      drive(1'b1, 32'h00500293, 32'h210);
      step();
      check("post_flush_valid", 32'(ex_valid), 32'd1);
      check("post_flush_pc", ex_pc, 32'h210);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("post_flush_empty", 32'(ex_valid), 32'd0);

      // ---------------- reset with a stalled bundle ----------------
      ex_ready = 1'b0;
      drive(1'b1, 32'h00600313, 32'h300);
      step();
      check("stall_valid", 32'(ex_valid), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      reset_n = 1'b0;
      step();
      check("rst2_valid", 32'(ex_valid), 32'd0);
      check("rst2_instr", ex_instr, 32'h00000013);
      check("rst2_if_ready", 32'(if_ready), 32'd0);
      reset_n  = 1'b1;
      ex_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst2_no_reappear", 32'(ex_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode stage. It accepts fetched instruction/PC pairs from the fetch stage over a valid/ready handshake.
- It decodes RV32I fields, immediates and control signals, and presents them to the execute stage as a registered output.
- A 2-entry buffer (output register plus skid register) lets the upstream ready signal come from a register, and absorbs one beat when execute stalls.
- Flush input drops in-flight instructions on branch/jump redirect.

Parameters:
XLEN, 32, data/PC width
NOP_INSTR, 32'h00000013, instruction value held on ex_instr when the stage is empty

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active-low
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage can accept this cycle
if_instr  in  32  fetched instruction
if_pc  in  32  PC of if_instr
flush  in  1  discard all held and incoming instructions
ex_valid  out  1  decoded bundle valid
ex_ready  in  1  execute accepts the bundle
ex_pc  out  32  PC of the decoded instruction
ex_instr  out  32  raw instruction
ex_rd, ex_rs1, ex_rs2  out  5 each  register indices
ex_funct3  out  3  funct3 field
ex_funct7  out  7  funct7 field
ex_imm  out  32  sign-extended immediate
ex_reg_write  out  1  writes rd
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_branch  out  1  conditional branch
ex_jump  out  1  JAL/JALR
ex_alu_src  out  1  ALU operand B is the immediate
ex_illegal  out  1  unrecognised encoding

Behaviour:
- Reset (reset_n low at a clk edge):
  - ex_valid=0, skid_valid=0, if_ready=0 while reset_n is low.
  - ex_instr=NOP_INSTR; all other ex_* outputs 0.
  - Reset mid-stream discards everything. No bundle appears until a new if_valid beat is accepted.
- if_ready = reset_n & ~skid_valid (registered state only; no combinational path from ex_ready).
- Accept = if_valid & if_ready. Hand-off = ex_valid & ex_ready.
- Latency: an instruction accepted at edge N appears on ex_* after edge N, provided the output register is empty or handing off.
- Buffer transitions, evaluated per edge:
  - Output register empty or handing off:
    - If skid_valid, load the output from skid and clear skid.
    - Otherwise load the accepted beat, if any.
    - If skid_valid and a beat is accepted in the same cycle, the accepted beat goes to skid. This cannot occur in practice because if_ready=0 while skid is full; assert this.
  - Output register full and stalled (ex_ready=0): an accepted beat goes into skid; skid_valid becomes 1.
  - FIFO order is strictly preserved; no beat is duplicated or lost.
- Flush:
  - Has priority over everything except reset.
  - Next cycle ex_valid=0 and skid_valid=0.
  - A beat accepted in the flush cycle is dropped.
  - A hand-off in the flush cycle still counts as consumed by execute.
- Decode is performed before storage (both entries hold decoded bundles). Rules:
  - opcode 0110011 (OP): reg_write=1.
  - opcode 0010011 (OP-IMM): reg_write=1, alu_src=1; I-immediate.
  - opcode 0000011 (LOAD): reg_write=1, mem_read=1, alu_src=1; I-immediate.
  - opcode 0100011 (STORE): mem_write=1, alu_src=1; S-immediate.
  - opcode 1100011 (BRANCH): branch=1; B-immediate.
  - opcode 1101111 (JAL): jump=1, reg_write=1; J-immediate.
  - opcode 1100111 (JALR): jump=1, reg_write=1, alu_src=1; I-immediate.
  - opcodes 0110111 (LUI) and 0010111 (AUIPC): reg_write=1, alu_src=1; U-immediate.
- Immediate rules: all immediates are sign-extended from instr[31]. U-immediate = {instr[31:12], 12'b0}. B- and J-immediates have bit 0 = 0. R-type imm=0.
- reg_write is forced to 0 when rd==0.
- Illegal encodings: instr[1:0]!=2'b11, or any other opcode, gives illegal=1 with reg_write/mem_read/mem_write/branch/jump all 0. The bundle is still passed downstream with valid.
- When empty (ex_valid=0), ex_* hold their last values. The exception is ex_instr, which is NOP_INSTR after reset or flush.

Decomposition:
- Shared package rv32_pkg: opcode constants, an immediate-format enumeration (I, S, B, U, J, NONE), and a decoded-bundle struct/width constant reused by execute.
- One combinational sub-module, instr_decoder (instr in, decoded bundle out). id_stage contains only the buffering, handshake and flush logic around it.

Test Plan:
- Reset, then 0x00108093 (addi x1,x1,1) with ex_ready=1 -> one cycle later ex_valid=1, rd=1, rs1=1, imm=1, reg_write=1, alu_src=1, pc matches.
- 0x0020A423 (sw x2,8(x1)) -> imm=8, rs1=1, rs2=2, mem_write=1, reg_write=0. Also 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1.
- Stream 5 instructions, PCs 0x0..0x10, with ex_ready=0 for 3 cycles mid-stream -> if_ready drops after the second buffered beat. All 5 arrive in order, none lost or duplicated.
- Assert flush with both entries full and if_valid=1 -> next cycle ex_valid=0 and if_ready=1. Next accepted PC is the first post-flush beat.
- 0xFFFFFFFF -> illegal=1, all write/mem controls 0. 0x00000093 (addi x1,x0,0) with rd forced to 0 via 0x00000013 -> reg_write=0.
- reset_n low for one cycle with a stalled bundle held -> ex_valid=0, ex_instr=0x00000013. The bundle never reappears.
